// File: rtl/laser310_vz_loader.sv
`timescale 1ns/1ps
// VZ snapshot loader: parses the HPS download header, writes the payload into shared RAM, and patches the BASIC end pointer.
// Latency: data bytes reach RAM the cycle after capture if uncontested. CPU writes are granted in the same cycle, with no added latency.
// Backpressure: ioctl_wait is held while the one-byte holding register is full. cpu_wait is raised when a starved loader write takes the port.
module laser310_vz_loader #(
   parameter logic [7:0] VZ_INDEX   = 8'd1,
   parameter int         STARVE_MAX = 4
) (
   input  logic        CLK25MHZ,
   input  logic        RESET,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [15:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   output logic        ioctl_wait,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic        cpu_wait,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_din,
   output logic        ram_we,
   output logic        load_busy,
   output logic        load_done,
   output logic        load_err,
   output logic [7:0]  load_type,
   output logic [15:0] load_start
);

   typedef enum logic [2:0] {
      IDLE, HDR, DATA, PTR_LO, PTR_HI, DONE, ERR
   } state_t;

   localparam int          SW          = $clog2(STARVE_MAX + 2);
   localparam logic [7:0]  TYPE_BASIC  = 8'hF0;
   localparam logic [15:0] PTR_ADDR_LO = 16'h78F9;
   localparam logic [15:0] PTR_ADDR_HI = 16'h78FA;

   // "VZF0" magic, byte by byte
   function automatic logic [7:0] magic_a(input logic [1:0] i);
      case (i)
         2'd0:    magic_a = 8'h56;
         2'd1:    magic_a = 8'h5A;
         2'd2:    magic_a = 8'h46;
         default: magic_a = 8'h30;
      endcase
   endfunction

   // " VZF" magic, byte by byte
   function automatic logic [7:0] magic_b(input logic [1:0] i);
      case (i)
         2'd0:    magic_b = 8'h20;
         2'd1:    magic_b = 8'h56;
         2'd2:    magic_b = 8'h5A;
         default: magic_b = 8'h46;
      endcase
   endfunction

   state_t        state, state_n;
   logic          hold_vld;
   logic [15:0]   hold_addr;
   logic [7:0]    hold_dat;
   logic [15:0]   data_count;
   logic          ok_a, ok_b;
   logic          ok_a_n, ok_b_n;
   logic [SW-1:0] starve_cnt;

   logic          vz_start, hdr_wr, data_wr, magic_bad;
   logic [15:0]   end_addr;
   logic          ld_pend, ld_gnt, cpu_act, cpu_gnt, starved;
   logic [15:0]   ld_addr;
   logic [7:0]    ld_dat;

   assign vz_start  = (state == IDLE) && ioctl_download && (ioctl_index == VZ_INDEX);
   assign hdr_wr    = (state == HDR) && ioctl_wr;
   assign ok_a_n    = ok_a && (ioctl_data == magic_a(ioctl_addr[1:0]));
   assign ok_b_n    = ok_b && (ioctl_data == magic_b(ioctl_addr[1:0]));
   assign magic_bad = hdr_wr && (ioctl_addr == 16'd3) && !ok_a_n && !ok_b_n;
   assign data_wr   = (state == DATA) && ioctl_wr && !hold_vld && (ioctl_addr >= 16'd24);
   assign end_addr  = load_start + data_count;

   // Single write port: the CPU wins unless the loader has starved. Gating by RESET keeps all outputs quiet while reset is held.
   always_comb begin
      ld_pend = hold_vld || (state == PTR_LO) || (state == PTR_HI);
      ld_addr = hold_addr;
      ld_dat  = hold_dat;
      if (state == PTR_LO) begin
         ld_addr = PTR_ADDR_LO;
         ld_dat  = end_addr[7:0];
      end else if (state == PTR_HI) begin
         ld_addr = PTR_ADDR_HI;
         ld_dat  = end_addr[15:8];
      end
      starved  = (starve_cnt >= SW'(STARVE_MAX));
      cpu_act  = cpu_req && RESET;
      ld_gnt   = ld_pend && (!cpu_act || starved);
      cpu_gnt  = cpu_act && !ld_gnt;
      cpu_wait = cpu_act && !cpu_gnt;
      ram_we   = ld_gnt || cpu_gnt;
      ram_addr = ld_gnt ? ld_addr : (cpu_gnt ? cpu_addr : 16'h0000);
      ram_din  = ld_gnt ? ld_dat  : (cpu_gnt ? cpu_dout : 8'h00);
   end

   assign ioctl_wait = hold_vld;
   assign load_busy  = (state == HDR) || (state == DATA) || (state == PTR_LO) || (state == PTR_HI);
   assign load_done  = (state == DONE);

   // State register
   always_ff @(posedge CLK25MHZ or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state logic. DATA only finishes once no byte is in flight, whether in the holding register or on the strobe.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (vz_start) state_n = HDR;
         HDR: begin
            if (magic_bad)                                state_n = ERR;
            else if (hdr_wr && (ioctl_addr == 16'd23))    state_n = DATA;
            else if (!ioctl_download)                     state_n = ERR;
         end
         DATA: begin
            if (!ioctl_download && !ioctl_wr && !hold_vld)
               state_n = (load_type == TYPE_BASIC) ? PTR_LO : DONE;
         end
         PTR_LO: if (ld_gnt) state_n = PTR_HI;
         PTR_HI: if (ld_gnt) state_n = DONE;
         DONE:   state_n = IDLE;
         ERR:    if (!ioctl_download) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Header capture, holding register, payload counter and error flag
   always_ff @(posedge CLK25MHZ or negedge RESET) begin
      if (!RESET) begin
         hold_vld   <= 1'b0;
         hold_addr  <= 16'h0000;
         hold_dat   <= 8'h00;
         data_count <= 16'h0000;
         ok_a       <= 1'b1;
         ok_b       <= 1'b1;
         load_err   <= 1'b0;
         load_type  <= 8'h00;
         load_start <= 16'h0000;
      end else begin
         if (vz_start) begin
            load_err   <= 1'b0;
            data_count <= 16'h0000;
            ok_a       <= 1'b1;
            ok_b       <= 1'b1;
         end
         if (hdr_wr) begin
            if (ioctl_addr < 16'd4) begin
               ok_a <= ok_a_n;
               ok_b <= ok_b_n;
            end
            if (ioctl_addr == 16'd21) load_type        <= ioctl_data;
            if (ioctl_addr == 16'd22) load_start[7:0]  <= ioctl_data;
            if (ioctl_addr == 16'd23) load_start[15:8] <= ioctl_data;
         end
         if ((state_n == ERR) && (state != ERR)) load_err <= 1'b1;
         if (data_wr) begin
            hold_vld   <= 1'b1;
            hold_addr  <= load_start + (ioctl_addr - 16'd24);
            hold_dat   <= ioctl_data;
            data_count <= data_count + 16'd1;
         end else if (hold_vld && ld_gnt) begin
            hold_vld <= 1'b0;
         end
      end
   end

   // Counts consecutive cycles a pending loader write has lost to the CPU
   always_ff @(posedge CLK25MHZ or negedge RESET) begin
      if (!RESET)                 starve_cnt <= '0;
      else if (!ld_pend || ld_gnt) starve_cnt <= '0;
      else if (!starved)          starve_cnt <= starve_cnt + 1'b1;
   end

endmodule

// File: doc/laser310_vz_loader.md
LASER310_VZ_LOADER -- requirements
Module: laser310_vz_loader

Parameters
REQ-001 VZ_INDEX, default 8'd1, ioctl_index value that selects a VZ snapshot download.
REQ-002 STARVE_MAX, default 4, number of consecutive cycles a pending loader write may lose arbitration before it is forced through.

Interface
REQ-003 CLK25MHZ  in  1  system clock; all logic on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  HPS download active.
REQ-006 ioctl_index  in  8  download slot index.
REQ-007 ioctl_wr  in  1  single-cycle byte strobe.
REQ-008 ioctl_addr  in  16  byte offset within file.
REQ-009 ioctl_data  in  8  file byte.
REQ-010 ioctl_wait  out  1  back-pressure to HPS; high = hold next strobe.
REQ-011 cpu_req  in  1  CPU RAM write request, held until granted.
REQ-012 cpu_addr  in  16  CPU write address.
REQ-013 cpu_dout  in  8  CPU write data.
REQ-014 cpu_wait  out  1  stall to Z80 WAIT logic.
REQ-015 ram_addr  out  16  shared RAM write address.
REQ-016 ram_din  out  8  shared RAM write data.
REQ-017 ram_we  out  1  shared RAM write enable, one cycle per write.
REQ-018 load_busy  out  1  high from first VZ byte until DONE or ERR.
REQ-019 load_done  out  1  one-cycle pulse on successful completion.
REQ-020 load_err  out  1  sticky bad-magic flag; cleared by the next VZ download start.
REQ-021 load_type  out  8  header type byte (F0 BASIC, F1 binary).
REQ-022 load_start  out  16  header start address.

Function
REQ-023 FSM states: IDLE, HDR, DATA, PTR_LO, PTR_HI, DONE, ERR.
- IDLE->HDR on ioctl_download=1 with ioctl_index=VZ_INDEX.
- Any other index: no transition and no ram_we.
REQ-024 HDR: capture bytes at offsets 0-23.
- 0-3 compared against "VZF0" or " VZF"; mismatch -> ERR.
- 21 -> load_type.
- 22-23 -> load_start, little-endian.
- Offset 23 -> DATA.
REQ-025 DATA: byte at offset N (N>=24) queued for RAM at load_start+(N-24), modulo 2^16 (wrap-around, no error).
REQ-026 Holding register: one byte.
- ioctl_wait=1 while the register is full.
- ioctl_wait falls the cycle after the byte is written.
- A strobe arriving while full is a protocol error from HPS; behaviour undefined, flagged by bench assertion.
REQ-027 Arbitration, single RAM write port, one write per cycle.
- CPU wins by default.
- Loader wins when cpu_req=0, or when its write has lost STARVE_MAX consecutive cycles.
- cpu_wait=1 in any cycle a pending cpu_req is not granted.
- CPU write latency is 0 cycles when granted: ram_we is asserted the same cycle as cpu_req, combinational grant.
REQ-028 Falling ioctl_download in DATA: drain the holding register first.
- load_type=F0 -> PTR_LO, else DONE.
REQ-029 PTR_LO/PTR_HI: arbitrated writes of end address E=load_start+data_count to 0x78F9 (low) and 0x78FA (high), then DONE.
REQ-030 DONE: pulse load_done, clear load_busy, -> IDLE.
REQ-031 ERR: set load_err, discard remaining bytes (ioctl_wait=0, no ram_we); ioctl_download fall -> IDLE.
REQ-032 Download ending before offset 23: -> ERR.
REQ-033 Simultaneous ioctl_download fall and last ioctl_wr: the byte is accepted and written before the PTR/DONE step.

Reset
REQ-034 RESET=0 asynchronously forces:
- IDLE, holding register empty;
- ioctl_wait=0, cpu_wait=0, ram_we=0, load_busy=0, load_done=0, load_err=0;
- load_type=0, load_start=0, ram_addr=0, ram_din=0.
REQ-035 Reset mid-load abandons the load; no pointer writes occur after release.

Verification
REQ-036 Binary VZ " VZF", type F1, start 0x8000, 3 data bytes AA BB CC, cpu_req=0 -> RAM[8000..8002]=AA,BB,CC; load_done pulses once; no writes to 78F9.
REQ-037 BASIC VZ "VZF0", type F0, start 0x7AE9, 2 bytes -> data written; then RAM[78F9]=EB, RAM[78FA]=7A.
REQ-038 cpu_req held continuously during DATA -> loader write forced after 4 lost cycles; cpu_wait=1 in exactly that cycle.
REQ-039 Magic "ABCD" -> load_err=1, no ram_we during the rest of the file; next valid download clears load_err.
REQ-040 Start 0xFFFF, 2 data bytes -> writes to FFFF then 0000.
REQ-041 RESET low during DATA with holding register full -> all outputs at reset values immediately; no further ram_we.
